// File: rtl/rv_producer.sv
// rv_producer: valid/ready burst producer emitting base, base+1, ... for len words
module rv_producer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [LEN_W-1:0] len,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx;
  // burst sequencing: data tracks base+idx so the offered word is already registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      idx   <= '0;
      data  <= '0;
    end else if (state == IDLE && start) begin
      state <= (len != '0) ? SEND : DONE;
      len_r <= len;
      idx   <= '0;
      data  <= base;
    end else if (state == SEND && ready) begin
      state <= (idx == len_r - LEN_W'(1)) ? DONE : SEND;
      idx   <= idx + LEN_W'(1);
      data  <= (idx == len_r - LEN_W'(1)) ? data : data + WIDTH'(1);
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign valid = (state == SEND);
  assign busy  = (state == SEND);
  assign done  = (state == DONE);
endmodule

// File: tb/tb_rv_producer.sv
// tb_rv_producer: scoreboard bench for the valid/ready burst producer
module tb_rv_producer;
  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       ready = 0;
  logic [7:0] base = 0;
  logic [3:0] len = 0;
  logic       valid, busy, done;
  logic [7:0] data;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dc;
  int n;
  bit vseen = 0;
  logic [7:0] q[$];

  rv_producer #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .ready(ready), .valid(valid), .data(data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      tick();
      cnt++;
      if (done) break;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (valid) vseen = 1;
    if (!rst && valid && ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer: unexpected word %0h with empty scoreboard", data);
      end else begin
        check("xfer_data", {24'd0, data}, {24'd0, q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_data", {24'd0, data}, 0);
    tick();

    q.push_back(8'h10); q.push_back(8'h11); q.push_back(8'h12);
    dc = done_cnt;
    start = 1; base = 8'h10; len = 4'd3; ready = 1;
    tick();
    start = 0;
    check("b1_busy", {31'd0, busy}, 1);
    wait_done(20, n);
    check("b1_cycles", n, 3);
    check("b1_valid_in_done", {31'd0, valid}, 0);
    tick();
    check("b1_done_low", {31'd0, done}, 0);
    check("b1_busy_low", {31'd0, busy}, 0);
    check("b1_done_cnt", done_cnt, dc + 1);

    q.push_back(8'h40); q.push_back(8'h41);
    dc = done_cnt;
    ready = 0; start = 1; base = 8'h40; len = 4'd2;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, valid}, 1);
      check("stall_data", {24'd0, data}, 32'h40);
      tick();
    end
    ready = 1;
    wait_done(20, n);
    check("bp_cycles", n, 2);
    tick();
    check("bp_done_cnt", done_cnt, dc + 1);

    q.push_back(8'hFE); q.push_back(8'hFF); q.push_back(8'h00);
    start = 1; base = 8'hFE; len = 4'd3;
    tick();
    start = 0;
    wait_done(20, n);
    check("wrap_cycles", n, 3);
    tick();
    vseen = 0;
    dc = done_cnt;
    start = 1; base = 8'h55; len = 4'd0;
    tick();
    start = 0;
    check("zl_done", {31'd0, done}, 1);
    check("zl_valid", {31'd0, valid}, 0);
    tick();
    check("zl_done_low", {31'd0, done}, 0);
    check("zl_busy", {31'd0, busy}, 0);
    check("zl_vseen", {31'd0, vseen}, 0);
    check("zl_done_cnt", done_cnt, dc + 1);

    q.push_back(8'h20); q.push_back(8'h21);
    dc = done_cnt;
    start = 1; base = 8'h20; len = 4'd5;
    tick();
    start = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mr_valid", {31'd0, valid}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_data", {24'd0, data}, 0);
    q.push_back(8'h30); q.push_back(8'h31);
    start = 1; base = 8'h30; len = 4'd2;
    tick();
    check("ig_busy", {31'd0, busy}, 1);
    base = 8'h99; len = 4'd7;
    tick();
    start = 0;
    tick();
    check("ig_done", {31'd0, done}, 1);
    start = 1;
    tick();
    start = 0;
    check("ig_idle_valid", {31'd0, valid}, 0);
    check("ig_idle_done", {31'd0, done}, 0);
    repeat (4) tick();
    check("mr_done_cnt", done_cnt, dc + 1);
    check("q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
